// File: rtl/fifo_bank.sv
// Bank of NUM_CH independent FIFOs with level/threshold flags, sticky error bits,
// a synchronous bank-wide flush and an optional first-word-fall-through read port.
module fifo_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_CH     = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int LW         = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_CH-1:0]            rd_en,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            almost_full,
  output logic [NUM_CH-1:0]            almost_empty,
  output logic [NUM_CH*LW-1:0]         level,
  input  logic                         err_clr,
  output logic [NUM_CH-1:0]            overflow,
  output logic [NUM_CH-1:0]            underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]         lvl;
    logic [DATA_WIDTH-1:0] head;
    logic                  is_full, is_empty, wr_ok, rd_ok;
    logic                  ovf_reg, unf_reg;

    // Pointers carry one extra wrap bit so their difference is the occupancy.
    assign lvl      = wr_ptr_reg - rd_ptr_reg;
    assign is_full  = (lvl == DEPTH_L);
    assign is_empty = (lvl == '0);
    assign wr_ok    = wr_en[gi] && !is_full && !flush;
    assign rd_ok    = rd_en[gi] && !is_empty && !flush;
    assign head     = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end

    // A new error event in the same cycle takes priority over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end else if (flush) begin
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end else begin
        if (wr_en[gi] && is_full) ovf_reg <= 1'b1;
        else if (err_clr)         ovf_reg <= 1'b0;
        if (rd_en[gi] && is_empty) unf_reg <= 1'b1;
        else if (err_clr)          unf_reg <= 1'b0;
      end
    end

    if (FWFT != 0) begin : g_fwft
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = is_empty ? '0 : head;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data_reg <= '0;
        else if (flush) rd_data_reg <= '0;
        else if (rd_ok) rd_data_reg <= head;
      end
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data_reg;
    end

    assign full[gi]             = is_full;
    assign empty[gi]            = is_empty;
    assign almost_full[gi]      = (int'(lvl) >= AF_THRESH);
    assign almost_empty[gi]     = (int'(lvl) <= AE_THRESH);
    assign level[gi*LW +: LW]   = lvl;
    assign overflow[gi]         = ovf_reg;
    assign underflow[gi]        = unf_reg;
  end

endmodule
